mem_responder: RTL
==================

# mem_responder

Word-addressed data-memory responder that serves the multi-cycle CPU's `MemRead`/`MemWrite` requests. It sits on the memory side of the controller/datapath boundary and holds the backing word RAM. It inserts a configurable number of wait states and returns a one-cycle `ready` pulse with read data and an error flag. The CPU controller holds its MEM state until `ready`, so the core tolerates slow memories.

## Interface
- `ADDR_WIDTH`, default 32: byte-address width.
- `DATA_WIDTH`, default 32: word width; only 32 is supported.
- `DEPTH_WORDS`, default 256: RAM depth in words; must be a power of two.
- `WAIT_CYCLES`, default 2: wait states per access; legal range 0..15.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `mem_read` in 1: read request.
- `mem_write` in 1: write request.
- `addr` in `ADDR_WIDTH`: byte address.
- `wdata` in `DATA_WIDTH`: write data.
- `rdata` out `DATA_WIDTH`: read data. Valid while `ready` is high; holds until the next access completes.
- `ready` out 1: one-cycle completion pulse.
- `error` out 1: qualifies `ready`; high means the access was rejected.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE:** on a clock edge with `mem_read | mem_write` high, capture `addr`, `wdata` and the op.
  - If `WAIT_CYCLES == 0`: perform the access at this edge and go to RESP.
  - Otherwise: load `cnt = WAIT_CYCLES-1` and go to WAIT.
- **WAIT:** decrement `cnt` each edge. On the edge where `cnt == 0`, perform the access and go to RESP.
- **RESP:** `ready = 1` for exactly one cycle, then return to IDLE unconditionally.
- Access rules:
  - Word index is `addr[log2(DEPTH_WORDS)+1:2]`.
  - Write: `ram[idx] <= wdata`; `rdata` is unchanged.
  - Read: `rdata <= ram[idx]`.
- Error cases: misaligned (`addr[1:0] != 0`), out of range (`addr[ADDR_WIDTH-1:log2(DEPTH_WORDS)+2] != 0`), or `mem_read & mem_write` both high at capture.
  - On error: no RAM write, `rdata <= 0`, `error = 1` during RESP.
- Requests are sampled only in IDLE. Input changes during WAIT/RESP are ignored; a captured transaction always completes.
- A request still high in the cycle after `ready` is sampled as a new transaction. The requester must drop the request in the `ready` cycle.
- Reset behaviour:
  - Reset forces IDLE, `ready = 0`, `error = 0`, `rdata = 0`, `cnt = 0`.
  - RAM contents are not reset.
  - Reset during WAIT aborts the access; no write occurs.

## Timing
- Request sampled at edge E0 → `ready` high during the cycle following edge E0+`WAIT_CYCLES`.
- Total latency is `WAIT_CYCLES+1` cycles; back-to-back throughput is one access per `WAIT_CYCLES+2` cycles.
- `ready`, `error` and `rdata` are all registered, with no combinational input-to-output paths.
- `error` is 0 whenever `ready` is 0.
- A write followed by a read of the same word returns the new data.

## Structure
- Shared package `mem_pkg` holds:
  - the state encoding (IDLE=2'b00, WAIT=2'b01, RESP=2'b10);
  - `WORD_BYTES = 4`;
  - the error-cause constants used by the bench.
- One sub-module, `sp_word_ram`: single-port synchronous RAM with 1 write and 1 read port, parameterised on depth and width, no reset.
- The FSM, counter and address checking stay in `mem_responder`.

## Test plan
- Defaults, write 0xDEADBEEF to 0x10, then read 0x10 → each `ready` pulse arrives 3 cycles after sampling; read returns 0xDEADBEEF with `error = 0`.
- `WAIT_CYCLES = 0`, read 0x0 after writing 0x12345678 → `ready` in the next cycle with `rdata = 0x12345678`.
- Read at 0x13 (misaligned) and at 0x400 (out of range for 256 words) → `ready` with `error = 1`, `rdata = 0`; RAM is unchanged, checked by a subsequent read of 0x10.
- `mem_read` and `mem_write` both high at 0x20 → `error = 1`; a later read of 0x20 returns the prior contents.
- Assert `reset` during WAIT of a write of 0xCAFEF00D to 0x30 → outputs are 0 immediately; a later read of 0x30 returns the old value.
- Request held high through `ready` → a second transaction starts in the following IDLE cycle, giving exactly two `ready` pulses `WAIT_CYCLES+2` cycles apart.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, word geometry
// and the classification of rejected accesses.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_OFS_W = $clog2(WORD_BYTES);

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_MISALIGNED = 2'd1,
        ERR_RANGE      = 2'd2,
        ERR_CONFLICT   = 2'd3
    } err_cause_e;

    // A simultaneous read+write is reported ahead of any address problem.
    function automatic err_cause_e classify_access(
        input logic misaligned,
        input logic out_of_range,
        input logic conflict
    );
        if (conflict)          return ERR_CONFLICT;
        else if (misaligned)   return ERR_MISALIGNED;
        else if (out_of_range) return ERR_RANGE;
        else                   return ERR_NONE;
    endfunction

endpackage

// File: rtl/sp_word_ram.sv
// Single-port word RAM: synchronous write, asynchronous read on the shared address.
// The caller registers the read data, so the RAM itself carries no output register.
module sp_word_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage arrays get no reset; resetting them would force flops instead of RAM macros.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Word-addressed data-memory responder with configurable wait states, returning
// a one-cycle ready pulse with registered read data and error flag.
module mem_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ready,
    output logic                  error
);

    import mem_pkg::*;

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_e                state, state_next;
    logic [3:0]            cnt;
    logic [IDX_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  write_q, err_q;

    logic                  req, capture, access;
    logic [IDX_W-1:0]      live_idx, acc_idx;
    logic [DATA_WIDTH-1:0] acc_wdata, ram_rdata;
    logic                  acc_write, acc_err, live_err, ram_we;
    err_cause_e            live_cause;

    assign req        = mem_read | mem_write;
    assign live_idx   = addr[IDX_W+BYTE_OFS_W-1:BYTE_OFS_W];
    assign live_cause = classify_access(addr[BYTE_OFS_W-1:0] != '0,
                                        (addr >> (IDX_W + BYTE_OFS_W)) != '0,
                                        mem_read & mem_write);
    assign live_err   = (live_cause != ERR_NONE);

    // With zero wait states the access happens on the capture edge itself, so
    // the RAM sees the live request instead of the captured copy.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_next = state;
        capture    = 1'b0;
        access     = 1'b0;
        acc_idx    = idx_q;
        acc_wdata  = wdata_q;
        acc_write  = write_q;
        acc_err    = err_q;
        unique case (state)
            IDLE: begin
                if (req) begin
                    capture = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        access     = 1'b1;
                        acc_idx    = live_idx;
                        acc_wdata  = wdata;
                        acc_write  = mem_write;
                        acc_err    = live_err;
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    access     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Reset is asynchronous, so the write strobe is blocked while it is held.
    assign ram_we = access && acc_write && !acc_err && !reset;

    sp_word_ram #(
        .DEPTH (DEPTH_WORDS),
        .WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (acc_idx),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= 4'd0;
            idx_q   <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            ready   <= 1'b0;
            error   <= 1'b0;
            rdata   <= '0;
        end else begin
            ready <= access;
            error <= access & acc_err;
            if (capture) begin
                idx_q   <= live_idx;
                wdata_q <= wdata;
                write_q <= mem_write;
                err_q   <= live_err;
                cnt     <= CNT_LOAD;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                if (acc_err)         rdata <= '0;
                else if (!acc_write) rdata <= ram_rdata;
            end
        end
    end

endmodule
